// File: rtl/arith_pkg.sv
// arith_pkg: shared opcode/state types and the golden arithmetic model.
// ref_model works at a fixed 64-bit width; callers truncate to ACC_W.
package arith_pkg;

    typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_MAC} op_e;
    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_e;

    localparam int REF_W = 64;

    function automatic logic [REF_W-1:0] ref_model(
        input logic [1:0]       op,
        input logic [31:0]      a,
        input logic [31:0]      b,
        input logic [REF_W-1:0] acc
    );
        logic [REF_W-1:0] ax;
        logic [REF_W-1:0] bx;
        ax = REF_W'(a);
        bx = REF_W'(b);
        case (op)
            OP_ADD:  ref_model = ax + bx;
            OP_SUB:  ref_model = ax - bx;
            OP_MUL:  ref_model = ax * bx;
            default: ref_model = acc + ax * bx;
        endcase
    endfunction

endpackage

// File: rtl/shift_add_mul.sv
// shift_add_mul: iterative unsigned shift-add multiplier, one bit per cycle.
// done is raised in the last iteration; product then already includes it.
module shift_add_mul
    import arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    logic [PW-1:0]    a_sh;
    logic [PW-1:0]    partial;
    logic [PW-1:0]    partial_nxt;
    logic [WIDTH-1:0] b_sh;
    logic [CW-1:0]    cnt;
    logic             run;

    assign partial_nxt = b_sh[0] ? partial + a_sh : partial;
    assign done        = run && (cnt == CW'(WIDTH - 1));
    assign product     = partial_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            run     <= 1'b0;
            cnt     <= '0;
            a_sh    <= '0;
            b_sh    <= '0;
            partial <= '0;
        end else if (start) begin
            run     <= 1'b1;
            cnt     <= '0;
            a_sh    <= PW'(a);
            b_sh    <= b;
            partial <= '0;
        end else if (run) begin
            partial <= partial_nxt;
            a_sh    <= a_sh << 1;
            b_sh    <= b_sh >> 1;
            cnt     <= cnt + 1'b1;
            if (done) run <= 1'b0;
        end
    end

endmodule

// File: rtl/arith_engine.sv
// arith_engine: handshaked ADD/SUB/MUL/MAC unit with a persistent accumulator.
// One transaction in flight; IDLE -> (ITER) -> DONE -> IDLE.
module arith_engine
    import arith_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ACC_W = 2 * WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] result,
    output logic             busy
);
    localparam int PW = 2 * WIDTH;

    state_e           state;
    state_e           state_nxt;
    op_e              op_q;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] result_q;
    logic [ACC_W-1:0] addsub;
    logic [ACC_W-1:0] mac_sum;
    logic [PW-1:0]    product;
    logic             accept;
    logic             is_mul;
    logic             mul_done;

    assign accept    = in_valid && in_ready;
    assign is_mul    = (op == OP_MUL) || (op == OP_MAC);
    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign result    = result_q;

    shift_add_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (accept && is_mul),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (product)
    );

    always_comb begin
        state_nxt = state;
        addsub    = ACC_W'(a) + ACC_W'(b);
        if (op == OP_SUB) addsub = ACC_W'(a) - ACC_W'(b);
        mac_sum   = acc + ACC_W'(product);
        unique case (state)
            S_IDLE:  if (accept) state_nxt = is_mul ? S_ITER : S_DONE;
            S_ITER:  if (mul_done) state_nxt = S_DONE;
            S_DONE:  if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            op_q     <= OP_ADD;
            acc      <= '0;
            result_q <= '0;
        end else begin
            state <= state_nxt;
            // a clear on the accept edge wins, so a MAC starts from zero
            if (in_ready && acc_clr) acc <= '0;
            if (accept) begin
                op_q <= op_e'(op);
                if (!is_mul) result_q <= addsub;
            end
            if (state == S_ITER && mul_done) begin
                result_q <= (op_q == OP_MAC) ? mac_sum : ACC_W'(product);
                if (op_q == OP_MAC) acc <= mac_sum;
            end
        end
    end

    ap_addsub: assert property (@(posedge clk) disable iff (reset)
        (accept && !is_mul) |=> result_q == ACC_W'(ref_model($past(op),
            32'($past(a)), 32'($past(b)), REF_W'($past(acc)))));

endmodule

// File: tb/tb_arith_engine.sv
// tb_arith_engine: randomized self-checking bench for arith_engine.
// Expected values come from a plain-arithmetic model with its own accumulator.
module tb_arith_engine;

    localparam int W  = 8;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    op;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          acc_clr;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] result;
    logic          busy;

    int total = 0;
    int bad   = 0;
    longint unsigned m_acc = 0;

    always #5 clk = ~clk;

    arith_engine #(.WIDTH(W), .ACC_W(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .acc_clr   (acc_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    task automatic predict(input logic [1:0] o, input logic [W-1:0] x,
                           input logic [W-1:0] y, input bit clr,
                           output logic [AW-1:0] e);
        longint unsigned xl, yl, v, mask;
        mask = (64'd1 << AW) - 64'd1;
        xl = 64'(x);
        yl = 64'(y);
        if (clr) m_acc = 0;
        case (o)
            2'd0:    v = xl + yl;
            2'd1:    v = xl - yl;
            2'd2:    v = xl * yl;
            default: v = m_acc + xl * yl;
        endcase
        v = v & mask;
        if (o == 2'd3) m_acc = v;
        e = AW'(v);
    endtask

    task automatic send(input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic clr,
                        output logic [AW-1:0] res, output int lat,
                        output bit busy_ok);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        in_valid = 1'b1; op = o; a = x; b = y;
        acc_clr = clr; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; acc_clr = 1'b0;
        lat = 1; busy_ok = 1'b1;
        while (!out_valid && lat < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; op = 2'd0; a = '0; b = '0;
        acc_clr = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        total++;
        if (result !== '0) begin
            bad++; $display("FAIL reset_result: got %0h want 0", result);
        end
        reset = 1'b0;
        m_acc = 0;
    endtask

    task automatic test_add();
        logic [AW-1:0] r, e;
        logic [W-1:0]  x, y;
        int lat; bit bz;
        send(2'd0, 8'd255, 8'd1, 1'b0, r, lat, bz);
        total++;
        if (r !== 16'd256) begin
            bad++; $display("FAIL add_255_1: got %0d want 256", r);
        end
        total++;
        if (lat != 1) begin
            bad++; $display("FAIL add_latency: got %0d want 1", lat);
        end
        repeat (10) begin
            x = W'($urandom); y = W'($urandom);
            predict(2'd0, x, y, 1'b0, e);
            send(2'd0, x, y, 1'b0, r, lat, bz);
            total++;
            if (r !== e || lat != 1) begin
                bad++;
                $display("FAIL add_rand %0d+%0d: got %0d lat %0d want %0d lat 1",
                         x, y, r, lat, e);
            end
        end
    endtask

    task automatic test_sub();
        logic [AW-1:0] r, e;
        logic [W-1:0]  x, y;
        int lat; bit bz;
        send(2'd1, 8'd3, 8'd5, 1'b0, r, lat, bz);
        total++;
        if (r !== 16'hFFFE) begin
            bad++; $display("FAIL sub_3_5: got %0h want fffe", r);
        end
        send(2'd1, 8'd200, 8'd100, 1'b0, r, lat, bz);
        total++;
        if (r !== 16'd100 || lat != 1) begin
            bad++; $display("FAIL sub_200_100: got %0d lat %0d want 100 lat 1", r, lat);
        end
        repeat (10) begin
            x = W'($urandom); y = W'($urandom);
            predict(2'd1, x, y, 1'b0, e);
            send(2'd1, x, y, 1'b0, r, lat, bz);
            total++;
            if (r !== e) begin
                bad++; $display("FAIL sub_rand %0d-%0d: got %0h want %0h", x, y, r, e);
            end
        end
    endtask

    task automatic test_mul();
        logic [AW-1:0] r, e;
        logic [W-1:0]  x, y;
        int lat; bit bz;
        send(2'd2, 8'd255, 8'd255, 1'b0, r, lat, bz);
        total++;
        if (r !== 16'd65025) begin
            bad++; $display("FAIL mul_255_255: got %0d want 65025", r);
        end
        total++;
        if (lat != W + 1) begin
            bad++; $display("FAIL mul_latency: got %0d want %0d", lat, W + 1);
        end
        total++;
        if (bz !== 1'b1) begin
            bad++; $display("FAIL mul_busy_iter: got %b want 1", bz);
        end
        repeat (8) begin
            x = W'($urandom); y = W'($urandom);
            predict(2'd2, x, y, 1'b0, e);
            send(2'd2, x, y, 1'b0, r, lat, bz);
            total++;
            if (r !== e || lat != W + 1) begin
                bad++;
                $display("FAIL mul_rand %0d*%0d: got %0d lat %0d want %0d lat %0d",
                         x, y, r, lat, e, W + 1);
            end
        end
    endtask

    task automatic test_mac();
        logic [AW-1:0] r, e;
        logic [W-1:0]  x, y;
        int lat; bit bz, c;
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        m_acc = 0;
        predict(2'd3, 8'd10, 8'd10, 1'b0, e);
        send(2'd3, 8'd10, 8'd10, 1'b0, r, lat, bz);
        total++;
        if (r !== 16'd100) begin
            bad++; $display("FAIL mac_10_10: got %0d want 100", r);
        end
        predict(2'd3, 8'd20, 8'd20, 1'b0, e);
        send(2'd3, 8'd20, 8'd20, 1'b0, r, lat, bz);
        total++;
        if (r !== 16'd500 || lat != W + 1) begin
            bad++; $display("FAIL mac_20_20: got %0d lat %0d want 500 lat %0d", r, lat, W + 1);
        end
        predict(2'd3, 8'd1, 8'd1, 1'b1, e);
        send(2'd3, 8'd1, 8'd1, 1'b1, r, lat, bz);
        total++;
        if (r !== 16'd1) begin
            bad++; $display("FAIL mac_clr_1_1: got %0d want 1", r);
        end
        repeat (8) begin
            x = W'($urandom); y = W'($urandom);
            c = ($urandom_range(0, 3) == 0);
            predict(2'd3, x, y, c, e);
            send(2'd3, x, y, c, r, lat, bz);
            total++;
            if (r !== e) begin
                bad++; $display("FAIL mac_rand %0d*%0d clr %0d: got %0d want %0d", x, y, c, r, e);
            end
        end
    endtask

    task automatic test_backpressure();
        int guard = 0;
        in_valid = 1'b1; op = 2'd2; a = 8'd12; b = 8'd12;
        acc_clr = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        op = 2'd0; a = 8'd1; b = 8'd1;
        while (!out_valid && guard < 40) begin
            @(posedge clk); #1;
            guard++;
        end
        total++;
        if (out_valid !== 1'b1 || result !== 16'd144) begin
            bad++; $display("FAIL bp_first: got v=%b %0d want v=1 144", out_valid, result);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 16'd144) begin
                bad++;
                $display("FAIL bp_hold[%0d]: got v=%b rdy=%b %0d want v=1 rdy=0 144",
                         i, out_valid, in_ready, result);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL bp_release: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        total++;
        if (out_valid !== 1'b1 || result !== 16'd2) begin
            bad++; $display("FAIL bp_resume: got v=%b %0d want v=1 2", out_valid, result);
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [AW-1:0] r, e;
        int lat; bit bz;
        predict(2'd3, 8'd3, 8'd3, 1'b0, e);
        send(2'd3, 8'd3, 8'd3, 1'b0, r, lat, bz);
        total++;
        if (r !== e) begin
            bad++; $display("FAIL mid_pre_mac: got %0d want %0d", r, e);
        end
        in_valid = 1'b1; op = 2'd2; a = 8'd7; b = 8'd9; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_acc = 0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got v=%b rdy=%b busy=%b want v=0 rdy=1 busy=0",
                     out_valid, in_ready, busy);
        end
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL mid_no_ghost: got v=%b want 0", out_valid);
        end
        predict(2'd3, 8'd1, 8'd1, 1'b0, e);
        send(2'd3, 8'd1, 8'd1, 1'b0, r, lat, bz);
        total++;
        if (r !== 16'd1) begin
            bad++; $display("FAIL mid_acc_zero: got %0d want 1", r);
        end
        send(2'd0, 8'd2, 8'd2, 1'b0, r, lat, bz);
        total++;
        if (r !== 16'd4) begin
            bad++; $display("FAIL mid_add_2_2: got %0d want 4", r);
        end
    endtask

    task automatic test_random_mix();
        logic [AW-1:0] r, e;
        logic [W-1:0]  x, y;
        logic [1:0]    o;
        int lat, want_lat; bit bz, c;
        repeat (40) begin
            o = 2'($urandom);
            x = W'($urandom); y = W'($urandom);
            c = ($urandom_range(0, 4) == 0);
            want_lat = (o < 2'd2) ? 1 : W + 1;
            predict(o, x, y, c, e);
            send(o, x, y, c, r, lat, bz);
            total++;
            if (r !== e || lat != want_lat) begin
                bad++;
                $display("FAIL mix op%0d %0d,%0d clr %0d: got %0h lat %0d want %0h lat %0d",
                         o, x, y, c, r, lat, e, want_lat);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_mul();
        test_mac();
        test_backpressure();
        test_reset_mid();
        test_random_mix();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
